// File: rtl/uart_mem_dump_if.sv
// Bundled control, status, memory-read and serial-line signals of the UART memory dumper.
// master = the dumper itself, slave = the host/memory side.
interface uart_mem_dump_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic [ADDR_W-1:0] base_adr;
  logic [ADDR_W:0]   word_cnt;
  logic              busy;
  logic              done;
  logic              mem_ren_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic [31:0]       mem_dat_i;
  logic              tx;

  modport master (
    input  start, base_adr, word_cnt, mem_dat_i,
    output busy, done, mem_ren_o, mem_adr_o, tx
  );

  modport slave (
    output start, base_adr, word_cnt, mem_dat_i,
    input  busy, done, mem_ren_o, mem_adr_o, tx
  );
endinterface

// File: rtl/uart_mem_dump.sv
// Reads word_cnt 32-bit words from a sync-read RAM and sends them 8N1, LSB first, little-endian.
// Optional trailing XOR checksum frame when UART_DUMP_CHECKSUM_EN is defined.
module uart_mem_dump #(
  parameter int CLK_FREQ = 23_000_000,
  parameter int BAUD     = 128_000,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  uart_mem_dump_if.master   bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_NEXT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [31:0]       shift_word;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              ren_r;
  logic [ADDR_W-1:0] adr_r;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]        csum;
  logic              csum_phase;
`endif

  assign bus.tx        = tx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.mem_ren_o = ren_r;
  assign bus.mem_adr_o = adr_r;

  // NOTE: all state and outputs are registered here with <= so every field updates on
  // the same edge; blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      shift_word <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ren_r      <= 1'b0;
      adr_r      <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      ren_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr      <= bus.base_adr;
            remaining <= bus.word_cnt;
`ifdef UART_DUMP_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
            if (bus.word_cnt == '0) begin
              done_r <= 1'b1;
            end else begin
              busy_r <= 1'b1;
              ren_r  <= 1'b1;
              adr_r  <= bus.base_adr;
              state  <= S_FETCH;
            end
          end
        end

        S_FETCH: state <= S_WAIT;

        // Read data is only guaranteed in the cycle after the strobe, so it is captured
        // on the edge that enters LOAD.
        S_WAIT: begin
          shift_word <= bus.mem_dat_i;
`ifdef UART_DUMP_CHECKSUM_EN
          csum <= csum ^ bus.mem_dat_i[7:0] ^ bus.mem_dat_i[15:8]
                       ^ bus.mem_dat_i[23:16] ^ bus.mem_dat_i[31:24];
`endif
          state <= S_LOAD;
        end

        S_LOAD: begin
          byte_idx <= '0;
          tx_r     <= 1'b0;
          baud_cnt <= BAUD_RELOAD;
          state    <= S_START;
        end

        S_START: begin
          if (baud_cnt == '0) begin
            tx_r       <= shift_word[0];
            shift_word <= shift_word >> 1;
            bit_idx    <= '0;
            baud_cnt   <= BAUD_RELOAD;
            state      <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        // The word shifts right once per data bit, so after eight bits the next byte
        // already sits in the low bits.
        S_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= S_STOP;
            end else begin
              tx_r       <= shift_word[0];
              shift_word <= shift_word >> 1;
              bit_idx    <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (baud_cnt == '0) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              tx_r     <= 1'b0;
              baud_cnt <= BAUD_RELOAD;
              state    <= S_START;
            end else begin
`ifdef UART_DUMP_CHECKSUM_EN
              if (csum_phase) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state <= S_NEXT;
              end
`else
              state <= S_NEXT;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        S_NEXT: begin
          remaining <= remaining - (ADDR_W + 1)'(1);
          if (remaining != (ADDR_W + 1)'(1)) begin
            addr  <= addr + ADDR_W'(1);
            adr_r <= addr + ADDR_W'(1);
            ren_r <= 1'b1;
            state <= S_FETCH;
          end else begin
`ifdef UART_DUMP_CHECKSUM_EN
            // Checksum goes out as a single-byte frame: byte index 3 ends it after one stop.
            shift_word <= {24'h0, csum};
            csum_phase <= 1'b1;
            byte_idx   <= 2'd3;
            tx_r       <= 1'b0;
            baud_cnt   <= BAUD_RELOAD;
            state      <= S_START;
`else
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_IDLE;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Self-checking bench for uart_mem_dump: cycle-accurate timeline model plus a UART receiver.
// Define UART_DUMP_CHECKSUM_EN for both RTL and bench to exercise the checksum frame.
module tb_uart_mem_dump;

  localparam int ADDR_W = 14;
  localparam int PER    = 404;  // FETCH + WAIT + LOAD + 4 frames of 100 + NEXT
`ifdef UART_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk;
  logic rst;
  uart_mem_dump_if #(.ADDR_W(ADDR_W)) bus ();

  uart_mem_dump #(.CLK_FREQ(1000), .BAUD(100), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read memory with one cycle of latency
  logic [31:0] mem [0:16383];
  logic [31:0] rdata;
  initial rdata = '0;
  always @(posedge clk) if (bus.mem_ren_o) rdata <= mem[bus.mem_adr_o];
  assign bus.mem_dat_i = rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model state
  bit              m_active = 0;
  int              m_k = 0;
  logic [13:0]     m_base = '0;
  int              m_n = 0;
  logic [13:0]     m_last_adr = '0;
  int              done_k = -1;
  logic [7:0]      rx_q [$];
  logic [13:0]     adr_q [$];

  function automatic logic frame_bit(input logic [7:0] v, input int p);
    int b;
    b = p / 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return v[b-1];
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] c;
    logic [31:0] w;
    c = '0;
    for (int i = 0; i < m_n; i++) begin
      w = mem[14'(int'(m_base) + i)];
      c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return c;
  endfunction

  // Expected outputs for cycle k after the accepting edge (k=1 is the first cycle after it)
  task automatic model_at(input int k, output logic e_tx, output logic e_busy,
                          output logic e_done, output logic e_ren,
                          output logic [13:0] e_adr, output bit fin);
    int total, clen, w, r, b, p;
    logic [31:0] word;
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ren = 1'b0; e_adr = '0; fin = 0;
    total = PER * m_n;
    clen  = (CSUM && m_n > 0) ? 100 : 0;
    if (m_n == 0) begin
      e_done = (k == 1);
      fin    = 1;
    end else if (k <= total) begin
      e_busy = 1'b1;
      w = (k - 1) / PER;
      r = (k - 1) % PER;
      if (r == 0) begin
        e_ren = 1'b1;
        e_adr = 14'(int'(m_base) + w);
      end else if (r >= 3 && r <= 402) begin
        b    = (r - 3) / 100;
        p    = (r - 3) % 100;
        word = mem[14'(int'(m_base) + w)];
        e_tx = frame_bit(word[8*b +: 8], p);
      end
    end else if (k <= total + clen) begin
      e_busy = 1'b1;
      e_tx   = frame_bit(model_csum(), k - total - 1);
    end else begin
      e_done = (k == total + clen + 1);
      fin    = 1;
    end
  endtask

  // Per-cycle compare, sampled 2 time units after each rising edge
  initial begin
    logic e_tx, e_busy, e_done, e_ren;
    logic [13:0] e_adr;
    bit fin;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_ren_o) adr_q.push_back(bus.mem_adr_o);
      if (m_active) begin
        m_k++;
        model_at(m_k, e_tx, e_busy, e_done, e_ren, e_adr, fin);
        if (e_ren) m_last_adr = e_adr;
        if (bus.done) done_k = m_k;
        if (fin) m_active = 0;
      end else begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ren = 1'b0;
      end
      check("tx", bus.tx, e_tx);
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      check("mem_ren_o", bus.mem_ren_o, e_ren);
      check("mem_adr_o", bus.mem_adr_o, m_last_adr);
    end
  end

  // Independent line receiver: samples mid-bit, pushes decoded bytes
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    logic [7:0] b;
    forever begin
      tick(1);
      if (!rst && bus.tx === 1'b0) begin
        tick(4);
        if (bus.tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            tick(10);
            b[i] = bus.tx;
          end
          tick(10);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic run_dump(input logic [13:0] base, input int n);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.base_adr = base;
    bus.word_cnt = 15'(n);
    m_base   = base;
    m_n      = n;
    m_k      = 0;
    done_k   = -1;
    m_active = 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_active && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("dump_timeout", 32'(m_active), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_k(input int k);
    int t = 0;
    while (m_k < k && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("wait_k_timeout", 32'(m_k >= k), 1);
  endtask

  task automatic clear_q();
    rx_q.delete();
    adr_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'(i) * 32'h9E37_79B1;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.base_adr = '0;
    bus.word_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ren", bus.mem_ren_o, 0);
    check("rst_adr", bus.mem_adr_o, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Case 1: single word, byte order and done timing
    mem[5] = 32'h1234_5678;
    clear_q();
    run_dump(14'd5, 1);
    wait_idle();
    check("c1_nreads", adr_q.size(), 1);
    check("c1_adr0", adr_q[0], 5);
    check("c1_nbytes", rx_q.size(), CSUM ? 5 : 4);
    check("c1_b0", rx_q[0], 8'h78);
    check("c1_b1", rx_q[1], 8'h56);
    check("c1_b2", rx_q[2], 8'h34);
    check("c1_b3", rx_q[3], 8'h12);
    check("c1_done_k", done_k, CSUM ? 505 : 405);

    // Case 2: address wrap-around
    mem[14'h3FFF] = 32'h0000_00A5;
    mem[0]        = 32'h0000_005A;
    clear_q();
    run_dump(14'h3FFF, 2);
    wait_idle();
    check("c2_nreads", adr_q.size(), 2);
    check("c2_adr0", adr_q[0], 32'h3FFF);
    check("c2_adr1", adr_q[1], 0);
    check("c2_w0b0", rx_q[0], 8'hA5);
    check("c2_w1b0", rx_q[4], 8'h5A);
    check("c2_w1b1", rx_q[5], 8'h00);

    // Case 3: zero words
    clear_q();
    run_dump(14'h123, 0);
    wait_idle();
    check("c3_done_k", done_k, 1);
    check("c3_nbytes", rx_q.size(), 0);
    check("c3_nreads", adr_q.size(), 0);

    // Case 4: start while busy is ignored
    mem[14'h20] = 32'hCAFE_F00D;
    mem[14'h21] = 32'h0BAD_BEEF;
    clear_q();
    run_dump(14'h20, 2);
    wait_k(300);
    bus.start = 1'b1; bus.base_adr = 14'd9; bus.word_cnt = 15'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_k(404);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check("c4_nreads", adr_q.size(), 2);
    check("c4_adr0", adr_q[0], 32'h20);
    check("c4_adr1", adr_q[1], 32'h21);
    check("c4_b0", rx_q[0], 8'h0D);
    check("c4_b3", rx_q[3], 8'hCA);
    check("c4_b4", rx_q[4], 8'hEF);
    check("c4_b7", rx_q[7], 8'h0B);

    // Case 5: asynchronous reset during a data bit of byte 2, then a clean dump
    mem[14'h40] = 32'h1122_3344;
    run_dump(14'h40, 1);
    wait_k(249);
    #1;
    rst = 1'b1;
    m_active   = 0;
    m_last_adr = '0;
    #1;
    check("c5_async_tx", bus.tx, 1);
    check("c5_async_busy", bus.busy, 0);
    check("c5_async_adr", bus.mem_adr_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    mem[14'h50] = 32'hDEAD_BEEF;
    mem[14'h51] = 32'h0102_0304;
    clear_q();
    run_dump(14'h50, 2);
    wait_idle();
    check("c5_nreads", adr_q.size(), 2);
    check("c5_adr1", adr_q[1], 32'h51);
    check("c5_b0", rx_q[0], 8'hEF);
    check("c5_b3", rx_q[3], 8'hDE);
    check("c5_b4", rx_q[4], 8'h04);
    check("c5_b7", rx_q[7], 8'h01);

`ifdef UART_DUMP_CHECKSUM_EN
    // Case 6: checksum frame after Case 1 data
    clear_q();
    run_dump(14'd5, 1);
    wait_idle();
    check("c6_nbytes", rx_q.size(), 5);
    check("c6_csum", rx_q[4], 8'h08);
    check("c6_done_k", done_k, 505);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
